// File: rtl/dm_arbiter.sv
// Purpose: round-robin arbiter with bounded lock sharing one data-memory port between CPU (port 0) and debug/DMA (port 1).
// Latency: req seen in IDLE cycle N -> ack and DM access in N+1 -> rvalid/rdata in N+2; one access every 2 cycles.
// Backpressure: requester holds req and command until ack; a req dropped before its ack is simply never granted.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   req/we/addr/wdata/pc  per-port command (0 = CPU, 1 = debug/DMA)
//   lock0/1               sampled in the ack cycle; keeps priority for the next grant
//   ack0/1                one-cycle pulse when the port's access is on the DM bus
//   rvalid0/1, rdata0/1   registered read return, one cycle after a read ack
//   dm_address/dm_data/dm_WE/dm_pc, dm_out   data-memory side
module dm_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [31:0]   pc0,
  input  logic [31:0]   pc1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          ack0,
  output logic          ack1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] dm_address,
  output logic [DW-1:0] dm_data,
  output logic          dm_WE,
  output logic [31:0]   dm_pc,
  input  logic [DW-1:0] dm_out
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t        state;
  logic          last;       // port that received the most recent grant
  logic          pend_vld;   // a lock request is outstanding ...
  logic          pend_port;  // ... for this port
  logic [CW-1:0] lock_cnt;   // locked grants issued back-to-back to pend_port

  logic grant;               // winning port when leaving IDLE
  logic busy;                // an access is on the DM bus this cycle
  logic cur;                 // port owning the current BUSY cycle
  logic cur_we;
  logic cur_lock;

  // Contention only matters when both request. A pending lock wins until
  // it has been honoured LOCK_MAX times in a row, then round robin forces
  // the other port in.
  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      if (pend_vld && (lock_cnt < LOCK_LIM)) grant = pend_port;
      else                                   grant = ~last;
    end else begin
      grant = req1;
    end
  end

  assign cur      = (state == BUSY1);
  assign cur_we   = cur ? we1 : we0;
  assign cur_lock = cur ? lock1 : lock0;

  // Bus outputs decode the registered state. They are gated by reset so a
  // BUSY cycle coinciding with reset assertion never writes or acks.
  assign busy       = reset && (state == BUSY0 || state == BUSY1);
  assign ack0       = reset && (state == BUSY0);
  assign ack1       = reset && (state == BUSY1);
  assign dm_WE      = busy && cur_we;
  assign dm_address = busy ? (cur ? addr1  : addr0)  : '0;
  assign dm_data    = busy ? (cur ? wdata1 : wdata0) : '0;
  assign dm_pc      = busy ? (cur ? pc1    : pc0)    : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      pend_vld  <= 1'b0;
      pend_port <= 1'b0;
      lock_cnt  <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) state <= grant ? BUSY1 : BUSY0;
        end
        BUSY0, BUSY1: begin
          state <= IDLE;
          last  <= cur;
          if (!cur_we) begin
            if (cur) begin
              rdata1  <= dm_out;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= dm_out;
              rvalid0 <= 1'b1;
            end
          end
          if (cur_lock) begin
            // The grant that raises the lock was won normally; only the
            // follow-on grants it buys are counted. Saturate so a lone
            // requester cannot wrap the counter and dodge the handover.
            pend_vld  <= 1'b1;
            pend_port <= cur;
            if (pend_vld && pend_port == cur) begin
              if (lock_cnt != LOCK_LIM) lock_cnt <= lock_cnt + 1'b1;
            end else begin
              lock_cnt <= '0;
            end
          end else begin
            pend_vld <= 1'b0;
            lock_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Purpose: directed self-checking bench for dm_arbiter with a word-addressed DM model and ack/read scoreboards.
// Latency: expectations are pushed when a request is driven and popped when the DUT acks or returns read data.
// Backpressure: every wait is bounded by a cycle budget; an expired budget counts as a mismatch.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1, pc0, pc1;
  logic        ack0, ack1, rvalid0, rvalid1, dm_WE;
  logic [31:0] rdata0, rdata1, dm_address, dm_data, dm_pc, dm_out;

  dm_arbiter #(.AW(32), .DW(32), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .pc0(pc0), .pc1(pc1), .lock0(lock0), .lock1(lock1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .dm_address(dm_address), .dm_data(dm_data), .dm_WE(dm_WE), .dm_pc(dm_pc),
    .dm_out(dm_out)
  );

  always #5 clk = ~clk;

  // Data memory: 64 words, combinational read, write on rising edge.
  logic [31:0] mem [0:63];
  assign dm_out = mem[dm_address[7:2]];
  always @(posedge clk) if (dm_WE) mem[dm_address[7:2]] <= dm_data;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   ack_cyc_q[$];
  int   rv_cyc_last = -1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_on = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      exp_t e;
      rd_t  r;
      chk("ack_exclusive", {63'd0, ack0 & ack1}, 64'd0);
      chk("we_only_on_ack", {63'd0, dm_WE & ~(ack0 | ack1)}, 64'd0);
      if (!ack0 && !ack1)
        chk("idle_bus_zero", {dm_address, dm_data | dm_pc}, 64'd0);
      if (ack0 || ack1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {62'd0, ack1, ack0}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", {63'd0, ack1}, {63'd0, e.port});
          chk("ack_we", {63'd0, dm_WE}, {63'd0, e.we});
          chk("ack_addr_data", {dm_address, dm_data}, {e.addr, e.wdata});
          chk("ack_pc", {32'd0, dm_pc}, {32'd0, e.pc});
          if (!e.we) rd_q.push_back('{e.port, e.rdata});
          ack_cyc_q.push_back(cyc);
        end
      end
      if (rvalid0 || rvalid1) begin
        rv_cyc_last = cyc;
        if (rd_q.size() == 0) begin
          chk("unexpected_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
        end else begin
          r = rd_q.pop_front();
          chk("rv_port", {62'd0, rvalid1, rvalid0}, r.port ? 64'd2 : 64'd1);
          chk("rdata", {32'd0, r.port ? rdata1 : rdata0}, {32'd0, r.rdata});
        end
      end
    end
  end

  task automatic wait_acks(input int n, input int budget);
    int b = 0;
    while (exp_q.size() > n && b < budget) begin
      @(posedge clk);
      b++;
    end
    chk("ack_timeout", 64'(exp_q.size() > n), 64'd0);
  endtask

  task automatic wait_reads(input int budget);
    int b = 0;
    while (rd_q.size() > 0 && b < budget) begin
      @(posedge clk);
      b++;
    end
    chk("rvalid_timeout", 64'(rd_q.size()), 64'd0);
  endtask

  // One isolated access; called just after a rising edge with the arbiter idle.
  task automatic do_access(input logic p, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] pc, input logic [31:0] rexp);
    int t0;
    exp_q.push_back('{p, w, a, d, pc, rexp});
    if (!p) begin we0 = w; addr0 = a; wdata0 = d; pc0 = pc; req0 = 1'b1; end
    else    begin we1 = w; addr1 = a; wdata1 = d; pc1 = pc; req1 = 1'b1; end
    t0 = cyc;
    wait_acks(0, 20);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
    wait_reads(20);
    chk("ack_latency", 64'(ack_cyc_q[$] - t0), 64'd1);
    if (!w) chk("rvalid_latency", 64'(rv_cyc_last - t0), 64'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    reset = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; pc0 = 0; pc1 = 0;

    // Reset held two cycles: everything quiet.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {62'd0, ack1, ack0}, 64'd0);
    chk("rst_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
    chk("rst_rdata", {rdata1, rdata0}, 64'd0);
    chk("rst_bus", {dm_address, dm_data | dm_pc}, 64'd0);
    chk("rst_we", {63'd0, dm_WE}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    mon_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single write from CPU, then debug reads it back.
    do_access(1'b0, 1'b1, 32'h10, 32'hDEAD, 32'h100, 32'h0);
    chk("dm_word4", {32'd0, mem[4]}, 64'h0000_DEAD);
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h104, 32'hDEAD);
    chk("rdata1_hold", {32'd0, rdata1}, 64'h0000_DEAD);
    @(posedge clk); #1;
    // CPU write leaves last=0, so contention below starts with port 1.
    do_access(1'b0, 1'b1, 32'h20, 32'hBEEF, 32'h108, 32'h0);
    @(posedge clk); #1;

    // Contention without lock: 1,0,1,0 every two cycles; reads see write ordering.
    exp_q.push_back('{1'b1, 1'b0, 32'h20, 32'h0,    32'h300, 32'hBEEF});
    exp_q.push_back('{1'b0, 1'b1, 32'h20, 32'h1234, 32'h200, 32'h0});
    exp_q.push_back('{1'b1, 1'b0, 32'h20, 32'h0,    32'h300, 32'h1234});
    exp_q.push_back('{1'b0, 1'b1, 32'h20, 32'h1234, 32'h200, 32'h0});
    n0 = ack_cyc_q.size();
    we0 = 1; addr0 = 32'h20; wdata0 = 32'h1234; pc0 = 32'h200;
    we1 = 0; addr1 = 32'h20; wdata1 = 32'h0;    pc1 = 32'h300;
    req0 = 1; req1 = 1;
    wait_acks(0, 40);
    #1; req0 = 0; req1 = 0;
    wait_reads(20);
    for (int i = 1; i < 4; i++)
      chk("rr_spacing", 64'(ack_cyc_q[n0+i] - ack_cyc_q[n0+i-1]), 64'd2);
    @(posedge clk); #1;

    // Lock bound: port 1 first (last=0), then port 0 once by round robin plus
    // four locked grants, forced handover to 1, then plain round robin once
    // lock0 is withdrawn.
    exp_q.push_back('{1'b1, 1'b0, 32'h20, 32'h0, 32'h500, 32'h1234});
    for (int i = 0; i < 5; i++)
      exp_q.push_back('{1'b0, 1'b0, 32'h10, 32'h0, 32'h400, 32'hDEAD});
    exp_q.push_back('{1'b1, 1'b0, 32'h20, 32'h0, 32'h500, 32'h1234});
    exp_q.push_back('{1'b0, 1'b0, 32'h10, 32'h0, 32'h400, 32'hDEAD});
    exp_q.push_back('{1'b1, 1'b0, 32'h20, 32'h0, 32'h500, 32'h1234});
    we0 = 0; addr0 = 32'h10; wdata0 = 32'h0; pc0 = 32'h400;
    we1 = 0; addr1 = 32'h20; wdata1 = 32'h0; pc1 = 32'h500;
    lock0 = 1; lock1 = 0;
    req0 = 1; req1 = 1;
    wait_acks(2, 60);
    lock0 = 0;
    wait_acks(0, 20);
    #1; req0 = 0; req1 = 0;
    wait_reads(20);
    @(posedge clk); #1;

    // Reset asserted during the BUSY cycle of a write: dropped entirely.
    we0 = 1; addr0 = 32'h30; wdata0 = 32'h5555; pc0 = 32'h600; req0 = 1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_ack0", {63'd0, ack0}, 64'd0);
    chk("rstmid_we", {63'd0, dm_WE}, 64'd0);
    req0 = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
    chk("rstmid_rdata", {rdata1, rdata0}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    chk("rstmid_mem12", {32'd0, mem[12]}, 64'd0);
    #1;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h700, 32'hDEAD);

    repeat (2) @(posedge clk);
    chk("queues_drained", 64'(exp_q.size() + rd_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
